muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_calc.sv | 38 +++
 rtl/muldiv_unit.sv | 73 +++++++
 tb/tb_muldiv_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: md_op codes, latency defaults and FSM types shared by the multiply/divide unit and its users.
// MADD-family decode is enabled by the MDU_MADD_EN macro.
package mdu_pkg;
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADD  = 4'd7;
    localparam logic [3:0] MD_MADDU = 4'd8;
    localparam logic [3:0] MD_MSUB  = 4'd9;
    localparam logic [3:0] MD_MSUBU = 4'd10;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 8;
    typedef enum logic {IDLE, BUSY} state_e;
    function automatic logic is_div(input logic [3:0] op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction
    function automatic logic is_mul(input logic [3:0] op);
        logic m;
        m = op == MD_MULT || op == MD_MULTU;
`ifdef MDU_MADD_EN
        m = m || (op >= MD_MADD && op <= MD_MSUBU);
`endif
        return m;
    endfunction
endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational 64-bit {hi,lo} result for a latched multiply/divide operation.
// The accumulate input and MADD-family paths exist only when MDU_MADD_EN is defined.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MDU_MADD_EN
    input  logic [63:0] acc,
`endif
    output logic [63:0] res,
    output logic        wr
);
    logic [63:0] prod_s, prod_u, prod;
    logic [31:0] ma, mb, q, r, qs, rs;
    logic sa, sb, uns;
    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'b0, a} * {32'b0, b};
        uns    = op == MD_MULTU || op == MD_MADDU || op == MD_MSUBU;
        prod   = uns ? prod_u : prod_s;
        // Signed division works on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
        sa = op == MD_DIV && a[31];
        sb = op == MD_DIV && b[31];
        ma = sa ? -a : a;
        mb = (b == 32'd0) ? 32'd1 : sb ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        qs = (sa ^ sb) ? -q : q;
        rs = sa ? -r : r;
        res = is_div(op) ? {rs, qs} : prod;
`ifdef MDU_MADD_EN
        if (op >= MD_MADD) res = (op == MD_MADD || op == MD_MADDU) ? acc + prod : acc - prod;
`endif
        wr = !(is_div(op) && b == 32'd0);
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MIPS multiply/divide unit with HI/LO registers and a busy interlock.
// Defining MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU.
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    state_e state, state_n;
    logic [CNT_W-1:0] cnt, lat;
    logic [3:0] op_q;
    logic [31:0] a_q, b_q;
    logic [63:0] res;
    logic wr, accept, last;
    mdu_calc u_calc (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
`ifdef MDU_MADD_EN
        .acc({hi, lo}),
`endif
        .res(res),
        .wr (wr)
    );
    always_comb begin
        accept = start && (is_mul(md_op) || is_div(md_op));
        lat    = is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        last   = cnt == CNT_W'(1);
    end
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = (state == IDLE) ? (accept ? BUSY : IDLE) : (last ? IDLE : BUSY);
    end
    always_comb begin
        busy = state == BUSY;
    end
    // HI/LO change only on the final busy edge or via MTHI/MTLO while idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt  <= '0;
            op_q <= MD_NONE;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if (last && wr) {hi, lo} <= res;
        end else begin
            if (accept) begin
                op_q <= md_op;
                a_q  <= A;
                b_q  <= B;
                cnt  <= lat;
            end
            if (start && md_op == MD_MTHI) hi <= A;
            if (start && md_op == MD_MTLO) lo <= A;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed scoreboard bench; the monitor checks hi/lo and busy length on each completion or probe.
// Build with MDU_MADD_EN to exercise the accumulate operations.
module tb_muldiv_unit;
    import mdu_pkg::*;
    logic clk = 0, reset = 0, start = 0, probe = 0;
    logic [3:0] md_op = 0;
    logic [31:0] A = 0, B = 0;
    logic busy;
    logic [31:0] hi, lo;
    int compared = 0, mismatched = 0;
    typedef struct {
        logic [31:0] h;
        logic [31:0] l;
        int n;
        string s;
    } exp_t;
    exp_t sb[$];
    logic prev_busy = 0;
    int run = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .md_op(md_op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) run++;
        if ((prev_busy && busy !== 1'b1) || probe) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_output: hi=%h lo=%h with empty scoreboard", hi, lo);
            end else begin
                e = sb.pop_front();
                chk({e.s, ".hi"}, hi, e.h);
                chk({e.s, ".lo"}, lo, e.l);
                chk({e.s, ".busy_len"}, 32'(run), 32'(e.n));
            end
            run = 0;
        end
        prev_busy = (busy === 1'b1);
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        md_op = op;
        A = a;
        B = b;
        start = 1;
        cyc();
        start = 0;
    endtask

    task automatic do_probe;
        probe = 1;
        cyc();
        probe = 0;
    endtask

    task automatic wait_idle(input string s);
        int k = 0;
        while (busy !== 1'b0 && k < 100) begin
            cyc();
            k++;
        end
        if (busy !== 1'b0) begin
            compared++;
            mismatched++;
            $display("FAIL %s.timeout: busy=%b after 100 cycles, required 0", s, busy);
        end
    endtask

    task automatic run_op(input string s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int n);
        sb.push_back('{eh, el, n, s});
        issue(op, a, b);
        if (n > 0) wait_idle(s);
        else do_probe();
    endtask

    initial begin
        repeat (3) cyc();
        reset = 1;
        sb.push_back('{32'h0, 32'h0, 0, "reset"});
        do_probe();
        run_op("mult_neg", MD_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, 5);
        run_op("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        run_op("divu", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'hE, 10);
        run_op("div_negdivisor", MD_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10);
        run_op("mthi", MD_MTHI, 32'h11, 32'h0, 32'h11, 32'hFFFFFFFD, 0);
        run_op("mtlo", MD_MTLO, 32'h22, 32'h0, 32'h11, 32'h22, 0);
        run_op("divu_by0", MD_DIVU, 32'd5, 32'd0, 32'h11, 32'h22, 10);
        run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10);
        run_op("mtlo_1234", MD_MTLO, 32'h1234, 32'h0, 32'h0, 32'h1234, 0);
        run_op("multu_big", MD_MULTU, 32'h10000, 32'h10000, 32'h1, 32'h0, 5);
        run_op("div_b2b", MD_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 10);
        run_op("none", MD_NONE, 32'h55, 32'h66, 32'hFFFFFFFE, 32'hFFFFFFF2, 0);
        run_op("undef12", 4'd12, 32'h55, 32'h66, 32'hFFFFFFFE, 32'hFFFFFFF2, 0);
        // Second start lands on busy cycle 2 and must be ignored.
        sb.push_back('{32'h0, 32'hC, 5, "ignore_busy"});
        issue(MD_MULT, 32'd3, 32'd4);
        cyc();
        issue(MD_DIVU, 32'd9, 32'd1);
        wait_idle("ignore_busy");
        // MULT, MTHI on busy cycle 2, reset on busy cycle 3.
        sb.push_back('{32'h0, 32'h0, 3, "abort"});
        issue(MD_MULT, 32'd5, 32'd5);
        cyc();
        issue(MD_MTHI, 32'h99, 32'h0);
        reset = 0;
        cyc();
        reset = 1;
        repeat (8) cyc();
        sb.push_back('{32'h0, 32'h0, 0, "after_abort"});
        do_probe();
        run_op("mtlo_ones", MD_MTLO, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 0);
`ifdef MDU_MADD_EN
        run_op("maddu", MD_MADDU, 32'd1, 32'd1, 32'h1, 32'h0, 5);
        run_op("msub", MD_MSUB, 32'hFFFFFFFF, 32'd2, 32'h1, 32'h2, 5);
`else
        run_op("maddu_off", MD_MADDU, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 0);
        run_op("msub_off", MD_MSUB, 32'hFFFFFFFF, 32'd2, 32'h0, 32'hFFFFFFFF, 0);
`endif
        run_op("mthi_7", MD_MTHI, 32'h7, 32'h0, 32'h7, lo, 0);
        run_op("mtlo_5", MD_MTLO, 32'h5, 32'h0, 32'h7, 32'h5, 0);
        sb.push_back('{32'h0, 32'h0, 0, "rst_prio"});
        md_op = MD_MULT;
        A = 32'd3;
        B = 32'd3;
        start = 1;
        reset = 0;
        cyc();
        start = 0;
        reset = 1;
        do_probe();
        repeat (3) cyc();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
